// File: rtl/alu_serial_if.sv
// Request/response bundle for the byte-serial ALU.
// The master issues requests and consumes results; the slave is the ALU.
interface alu_serial_if #(
  parameter int NBYTES = 2
);
  localparam int W = 8 * NBYTES;

  logic         in_valid;
  logic         in_ready;
  logic [3:0]   opcode;
  logic [W-1:0] regA;
  logic [W-1:0] regB;
  logic         carryIn;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic [7:0]   flagsOut;

  modport master (
    output in_valid, opcode, regA, regB, carryIn, out_ready,
    input  in_ready, out_valid, res, flagsOut
  );

  modport slave (
    input  in_valid, opcode, regA, regB, carryIn, out_ready,
    output in_ready, out_valid, res, flagsOut
  );
endinterface

// File: rtl/alu_serial.sv
// Byte-serial Game Boy ALU: one byte slice per clock, with the carry/borrow/
// shift bit chained between slices. RR/BSR walk MSB-first, all else LSB-first.
//
// state | meaning
// IDLE  | ready for a request, outputs hold the last result
// EXEC  | processing one byte slice per cycle
// DONE  | result presented, waiting for out_ready
module alu_serial #(
  parameter int NBYTES = 2
) (
  input logic        clk,
  input logic        rst,
  alu_serial_if.slave bus
);
  localparam int W  = 8 * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [3:0] OP_ADD = 4'h0, OP_ADC = 4'h1, OP_SUB = 4'h2, OP_SBC = 4'h3,
                         OP_CP  = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
                         OP_RL  = 4'h8, OP_RR  = 4'h9, OP_BSL = 4'hA, OP_BSR = 4'hB,
                         OP_SWAP = 4'hC;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_n;

  logic [3:0]    op_q;
  logic [W-1:0]  a_q, b_q, acc, acc_n, res_q;
  logic [7:0]    flags_q, flags_n;
  logic          chain, zacc;
  logic [CW-1:0] cnt, idx;
  logic [CW+2:0] sh;
  logic          accept, last, msb_first;
  logic [7:0]    ab, bb, sb, zb;
  logic          cn, hn;
  logic [8:0]    t9;
  logic [4:0]    t5;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.res       = res_q;
  assign bus.flagsOut  = flags_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign last      = (cnt == CW'(NBYTES - 1));
  assign msb_first = (op_q == OP_RR) || (op_q == OP_BSR);
  assign idx       = msb_first ? (CW'(NBYTES - 1) - cnt) : cnt;
  assign sh        = {idx, 3'b000};
  assign ab        = 8'(a_q >> sh);
  assign bb        = 8'(b_q >> sh);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = EXEC;
      EXEC:    if (last) state_n = DONE;
      DONE:    if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // One byte slice: result byte, byte feeding Z, chain-out and nibble carry.
  always_comb begin
    sb = ab;
    zb = ab;
    cn = 1'b0;
    hn = 1'b0;
    t9 = '0;
    t5 = '0;
    case (op_q)
      OP_ADD, OP_ADC: begin
        t9 = {1'b0, ab} + {1'b0, bb} + {8'd0, chain};
        t5 = {1'b0, ab[3:0]} + {1'b0, bb[3:0]} + {4'd0, chain};
        sb = t9[7:0];
        zb = t9[7:0];
        cn = t9[8];
        hn = t5[4];
      end
      OP_SUB, OP_SBC, OP_CP: begin
        t9 = {1'b0, ab} - {1'b0, bb} - {8'd0, chain};
        t5 = {1'b0, ab[3:0]} - {1'b0, bb[3:0]} - {4'd0, chain};
        sb = (op_q == OP_CP) ? ab : t9[7:0];
        zb = t9[7:0];
        cn = t9[8];
        hn = t5[4];
      end
      OP_AND: begin sb = ab & bb; zb = sb; hn = 1'b1; end
      OP_OR:  begin sb = ab | bb; zb = sb; end
      OP_XOR: begin sb = ab ^ bb; zb = sb; end
      OP_RL, OP_BSL: begin sb = {ab[6:0], chain}; zb = sb; cn = ab[7]; end
      OP_RR, OP_BSR: begin sb = {chain, ab[7:1]}; zb = sb; cn = ab[0]; end
      OP_SWAP: begin sb = {ab[3:0], ab[7:4]}; zb = sb; end
      default: begin sb = ab; zb = ab; end
    endcase
  end

  // Merge the slice into the accumulator and form the final flags.
  always_comb begin
    acc_n   = (acc & ~(W'(8'hFF) << sh)) | (W'(sb) << sh);
    flags_n = 8'h00;
    if (op_q <= OP_SWAP)
      flags_n = {~(zacc | (|zb)),
                 (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CP),
                 hn, cn, 4'b0000};
  end

  // Operand latch and serial datapath; res/flags update only on the last slice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      chain   <= 1'b0;
      zacc    <= 1'b0;
      cnt     <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q  <= bus.opcode;
          a_q   <= bus.regA;
          b_q   <= bus.regB;
          acc   <= '0;
          zacc  <= 1'b0;
          cnt   <= '0;
          chain <= ((bus.opcode == OP_ADC) || (bus.opcode == OP_SBC) ||
                    (bus.opcode == OP_RL)  || (bus.opcode == OP_RR)) ? bus.carryIn : 1'b0;
        end
        EXEC: begin
          acc   <= acc_n;
          chain <= cn;
          zacc  <= zacc | (|zb);
          cnt   <= cnt + CW'(1);
          if (last) begin
            res_q   <= acc_n;
            flags_q <= flags_n;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
